// File: rtl/vga_fb_scanout_1bpp_if.sv
// Frame-buffer video read port plus board video output, grouped for the scanout engine.
//   vga_addr    : linear read address y*H_ACTIVE+x (engine -> frame buffer)
//   vga_dout    : read data, valid one clock after vga_addr (frame buffer -> engine)
//   red/green/blue, hsync, vsync, de, frame_start : registered video output (engine -> DAC)
interface vga_fb_scanout_1bpp_if;
    logic [19:0] vga_addr;
    logic        vga_dout;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;

    modport master (
        output vga_addr,
        input  vga_dout,
        output red, green, blue, hsync, vsync, de, frame_start
    );

    modport slave (
        input  vga_addr,
        output vga_dout,
        input  red, green, blue, hsync, vsync, de, frame_start
    );
endinterface

// File: rtl/vga_fb_scanout_1bpp.sv
// Read-side scanout engine for a 1-bit frame buffer: generates VGA timing,
// walks the frame buffer linearly and turns the 1-clk-latency read data into
// registered RGB/hsync/vsync/de with a fixed 2-clk latency from counter state.
//   clk  : pixel clock (also the frame buffer video port clock)
//   rst  : synchronous reset, active-high
//   bus  : master side of vga_fb_scanout_1bpp_if (read port + video output)
module vga_fb_scanout_1bpp #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          SYNC_POL = 1'b0,
    parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_fb_scanout_1bpp_if.master   bus
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned A_W      = 20;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic [A_W-1:0] addr_cnt_q, addr_cnt_d;

    logic active_c, hs_c, vs_c, first_px_c, h_last_c, v_last_c;

    logic        active_d1_q, hs_d1_q, vs_d1_q, first_px_d1_q;
    logic        de_q, hsync_q, vsync_q, frame_start_q;
    logic [23:0] rgb_q, rgb_d;

    // Timing decode and next-state for the counters and the linear address.
    always_comb begin
        h_last_c   = (h_cnt_q == H_W'(H_TOTAL - 1));
        v_last_c   = (v_cnt_q == V_W'(V_TOTAL - 1));
        active_c   = (h_cnt_q < H_W'(H_ACTIVE)) && (v_cnt_q < V_W'(V_ACTIVE));
        hs_c       = (h_cnt_q >= H_W'(HS_START)) && (h_cnt_q < H_W'(HS_END));
        vs_c       = (v_cnt_q >= V_W'(VS_START)) && (v_cnt_q < V_W'(VS_END));
        first_px_c = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d    = h_last_c ? '0 : h_cnt_q + H_W'(1);
        v_cnt_d    = v_cnt_q;
        if (h_last_c) begin
            v_cnt_d = v_last_c ? '0 : v_cnt_q + V_W'(1);
        end

        // Address only advances on visible pixels, so in blanking it already
        // holds the next line's start; cleared on the very last frame cycle.
        addr_cnt_d = addr_cnt_q;
        if (h_last_c && v_last_c) begin
            addr_cnt_d = '0;
        end else if (active_c) begin
            addr_cnt_d = addr_cnt_q + A_W'(1);
        end
    end

    // Colour is forced to zero outside active video regardless of read data.
    always_comb begin
        rgb_d = 24'h0;
        if (active_d1_q) begin
            rgb_d = bus.vga_dout ? FG_RGB : BG_RGB;
        end
    end

    // Counters, stage 1 (read in flight) and stage 2 (registered outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            addr_cnt_q    <= '0;
            active_d1_q   <= 1'b0;
            hs_d1_q       <= 1'b0;
            vs_d1_q       <= 1'b0;
            first_px_d1_q <= 1'b0;
            de_q          <= 1'b0;
            rgb_q         <= 24'h0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            active_d1_q   <= active_c;
            hs_d1_q       <= hs_c;
            vs_d1_q       <= vs_c;
            first_px_d1_q <= first_px_c;
            de_q          <= active_d1_q;
            rgb_q         <= rgb_d;
            hsync_q       <= hs_d1_q ^ ~SYNC_POL;
            vsync_q       <= vs_d1_q ^ ~SYNC_POL;
            frame_start_q <= first_px_d1_q;
        end
    end

    assign bus.vga_addr    = addr_cnt_q;
    assign bus.red         = rgb_q[23:16];
    assign bus.green       = rgb_q[15:8];
    assign bus.blue        = rgb_q[7:0];
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_scanout_1bpp.sv
// Self-checking bench for vga_fb_scanout_1bpp using a shrunken timing set so
// whole frames fit in a short run. A behavioural model derives every expected
// output from the raster position (plain div/mod arithmetic).
module tb_vga_fb_scanout_1bpp;

    localparam int HA  = 16;
    localparam int HFP = 3;
    localparam int HS  = 4;
    localparam int HBP = 5;
    localparam int VA  = 6;
    localparam int VFP = 2;
    localparam int VS  = 3;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;
    localparam int NPIX = HA * VA;
    localparam logic [23:0] FG = 24'hF0A5C3;
    localparam logic [23:0] BG = 24'h0F1E2D;

    typedef struct {
        int h;
        int v;
        int addr;
        bit de;
        bit hs;
        bit vs;
    } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_fb_scanout_1bpp_if bus ();

    vga_fb_scanout_1bpp #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0), .FG_RGB(FG), .BG_RGB(BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int     errors = 0;
    int     checks = 0;
    int     mode   = 0;
    bit     bitmap [NPIX];
    probe_t tbl [13];
    int     last_fs;
    int     first_fs;
    int     fs_cnt;

    // Frame-buffer contents as a function of address for the current mode.
    function automatic bit mem_bit(input int a);
        int unsigned av;
        av = a;
        case (mode)
            0:       return (a >= 0 && a < NPIX) ? bitmap[a] : 1'b0;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return av[0] ^ av[4];
        endcase
    endfunction

    // Synchronous-read memory: data appears one clock after the address.
    always @(posedge clk) bus.vga_dout <= mem_bit(int'(bus.vga_addr));

    // Address the engine should present while the raster sits at state s.
    function automatic int exp_addr(input int s);
        int h, v;
        h = s % HT;
        v = (s / HT) % VT;
        if (v < VA) return (h < HA) ? v * HA + h : (v + 1) * HA;
        return VA * HA;
    endfunction

    task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d mode=%0d actual=%0h required=%0h", name, n, mode, act, exp);
        end
    endtask

    task automatic check_cycle(input int n);
        int h, v, s, sh, sv;
        bit e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        h = n % HT;
        v = (n / HT) % VT;
        chk("vga_addr", n, 32'(bus.vga_addr), 32'(exp_addr(n)));
        foreach (tbl[i]) begin
            if (tbl[i].h == h && tbl[i].v == v)
                chk("probe_addr", n, 32'(bus.vga_addr), 32'(tbl[i].addr));
        end
        if (n < 2) begin
            chk("rst_de",    n, 32'(bus.de), 32'(0));
            chk("rst_rgb",   n, 32'({bus.red, bus.green, bus.blue}), 32'(0));
            chk("rst_hsync", n, 32'(bus.hsync), 32'(1));
            chk("rst_vsync", n, 32'(bus.vsync), 32'(1));
            chk("rst_fs",    n, 32'(bus.frame_start), 32'(0));
        end else begin
            s  = n - 2;
            sh = s % HT;
            sv = (s / HT) % VT;
            e_de  = (sh < HA) && (sv < VA);
            e_hs  = !((sh >= HA + HFP) && (sh < HA + HFP + HS));
            e_vs  = !((sv >= VA + VFP) && (sv < VA + VFP + VS));
            e_fs  = (sh == 0) && (sv == 0);
            e_rgb = e_de ? (mem_bit(exp_addr(s)) ? FG : BG) : 24'h0;
            chk("de",    n, 32'(bus.de), 32'(e_de));
            chk("hsync", n, 32'(bus.hsync), 32'(e_hs));
            chk("vsync", n, 32'(bus.vsync), 32'(e_vs));
            chk("fs",    n, 32'(bus.frame_start), 32'(e_fs));
            chk("rgb",   n, 32'({bus.red, bus.green, bus.blue}), 32'(e_rgb));
            foreach (tbl[i]) begin
                if (tbl[i].h == sh && tbl[i].v == sv) begin
                    chk("probe_de", n, 32'(bus.de), 32'(tbl[i].de));
                    chk("probe_hs", n, 32'(bus.hsync), 32'(tbl[i].hs));
                    chk("probe_vs", n, 32'(bus.vsync), 32'(tbl[i].vs));
                end
            end
        end
        if (bus.frame_start === 1'b1) begin
            if (last_fs >= 0) chk("fs_period", n, 32'(n - last_fs), 32'(FR));
            if (first_fs < 0) first_fs = n;
            last_fs = n;
            fs_cnt++;
        end
    endtask

    // Reset for rst_len clocks (possibly mid-frame), then check cycles states.
    task automatic run_phase(input int md, input int rst_len, input int cycles);
        mode = md;
        if (md == 0) foreach (bitmap[i]) bitmap[i] = 1'($urandom_range(0, 1));
        rst = 1'b1;
        repeat (rst_len) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_fs  = -1;
        first_fs = -1;
        fs_cnt   = 0;
        for (int n = 0; n < cycles; n++) begin
            if (n > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check_cycle(n);
        end
        if (cycles >= 3) begin
            chk("fs_first", cycles, 32'(first_fs), 32'(2));
            chk("fs_count", cycles, 32'(fs_cnt), 32'((cycles - 3) / FR + 1));
        end
    endtask

    initial begin
        // {h, v, addr at state, de/hsync/vsync two clocks later}
        tbl[0]  = '{0,  0,  0,  1'b1, 1'b1, 1'b1};
        tbl[1]  = '{15, 0,  15, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{16, 0,  16, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{18, 0,  16, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{19, 0,  16, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{22, 0,  16, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{23, 0,  16, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{0,  1,  16, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{15, 5,  95, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{27, 7,  96, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{0,  8,  96, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{27, 10, 96, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{0,  11, 96, 1'b0, 1'b1, 1'b1};

        run_phase(3, 5, 3 * FR + 10);
        run_phase(1, 2, FR + 5);
        run_phase(2, 2, FR + 5);
        run_phase(0, 3, 2 * FR);
        // Stop at line 4 pixel 10, then a single-clock reset mid-frame.
        run_phase(0, 5, 4 * HT + 11);
        run_phase(0, 1, 2 * FR + 5);
        // Randomly placed mid-frame reset.
        run_phase(3, 4, int'($urandom_range(20, FR - 20)));
        run_phase(0, 1, FR + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
